// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU datapath blocks.
// Holds the fetch FSM state encoding and default bus widths.
package cpu_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch sequencing FSM: owns the ROM handshake state and derives
// mem_req / instr_valid from it.
module fetch_ctrl_fsm
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_ack,
    input  logic         redirect_valid,
    input  logic         instr_ready,
    output fetch_state_t state,
    output logic         mem_req,
    output logic         instr_valid
);

    fetch_state_t next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next;
    end

    always_comb begin
        next        = state;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        case (state)
            S_IDLE: next = S_REQ;
            S_REQ: begin
                mem_req = 1'b1;
                // Redirect with ack completes the old request, so re-request at once
                if (redirect_valid && !mem_ack)      next = S_DRAIN;
                else if (mem_ack && !redirect_valid) next = S_HOLD;
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (redirect_valid || instr_ready) next = S_REQ;
            end
            S_DRAIN: begin
                mem_req = 1'b1;
                if (mem_ack) next = S_REQ;
            end
            default: next = S_IDLE;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, captured instruction and
// pending redirect target around the fetch control FSM.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_out
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pending;

    fetch_ctrl_fsm u_fsm (
        .clk            (clk),
        .reset          (reset),
        .mem_ack        (mem_ack),
        .redirect_valid (redirect_valid),
        .instr_ready    (instr_ready),
        .state          (state),
        .mem_req        (mem_req),
        .instr_valid    (instr_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            pending   <= '0;
            instr_out <= '0;
            instr_pc  <= '0;
        end else begin
            case (state)
                S_IDLE: if (redirect_valid) pc <= redirect_addr;
                S_REQ: begin
                    if (redirect_valid && mem_ack) pc <= redirect_addr;
                    else if (redirect_valid)       pending <= redirect_addr;
                    else if (mem_ack) begin
                        instr_out <= mem_rdata;
                        instr_pc  <= pc;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid)   pc <= redirect_addr;
                    else if (instr_ready) pc <= pc + ADDR_W'(1);
                end
                S_DRAIN: begin
                    // Latest redirect wins, even in the ack cycle
                    if (redirect_valid) pending <= redirect_addr;
                    if (mem_ack) pc <= redirect_valid ? redirect_addr : pending;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = pc;
    assign pc_out   = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stall,
// redirects in each state, PC wrap and reset mid-request.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_ack = 1'b0;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_addr = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc, pc_out;

    logic        mem_req2, mem_ack2 = 1'b0;
    logic [7:0]  mem_addr2;
    logic [15:0] mem_rdata2 = '0;
    logic        instr_valid2;
    logic [15:0] instr_out2;
    logic [7:0]  instr_pc2, pc_out2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc), .pc_out(pc_out)
    );

    instr_fetch_unit #(.RESET_PC(8'hFE)) dut2 (
        .clk(clk), .reset(reset),
        .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
        .redirect_valid(1'b0), .redirect_addr(8'h00),
        .instr_valid(instr_valid2), .instr_ready(1'b1),
        .instr_out(instr_out2), .instr_pc(instr_pc2), .pc_out(pc_out2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for a request, check its address is held for lat cycles, then ack.
    task automatic serve(input int lat, input logic [7:0] addr,
                         input logic [15:0] data);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", mem_req, 1);
        chk("req_addr", mem_addr, addr);
        for (int i = 1; i < lat; i++) begin
            chk("valid_during_req", instr_valid, 0);
            @(negedge clk);
            chk("req_held", mem_req, 1);
            chk("addr_held", mem_addr, addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("valid_after_ack", instr_valid, 1);
        chk("instr_out", instr_out, data);
        chk("instr_pc", instr_pc, addr);
        chk("req_low_in_hold", mem_req, 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_instr", instr_out, 16'h0);
        chk("rst_ipc", instr_pc, 8'h00);
        chk("rst_pc2", pc_out2, 8'hFE);
        @(negedge clk);
        reset = 1'b0;
        chk("idle_req", mem_req, 0);

        // Sequential fetch, ack latency 2, ready high
        instr_ready = 1'b1;
        serve(2, 8'h00, 16'hA000);
        serve(2, 8'h01, 16'hA001);
        @(negedge clk);
        instr_ready = 1'b0;
        serve(2, 8'h02, 16'hA002);

        // Stall in HOLD for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", instr_valid, 1);
            chk("stall_req", mem_req, 0);
            chk("stall_pc", pc_out, 8'h02);
            chk("stall_instr", instr_out, 16'hA002);
            chk("stall_ipc", instr_pc, 8'h02);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("post_stall_addr", mem_addr, 8'h03);
        serve(2, 8'h03, 16'hA003);

        // Redirect in HOLD squashes even with ready high
        redirect_valid = 1'b1;
        redirect_addr  = 8'h40;
        instr_ready    = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        chk("hold_redir_valid", instr_valid, 0);
        chk("hold_redir_addr", mem_addr, 8'h40);
        chk("hold_redir_req", mem_req, 1);
        serve(1, 8'h40, 16'hB040);

        // Move to pc=5, then redirect during REQ with late ack
        redirect_valid = 1'b1;
        redirect_addr  = 8'h05;
        @(negedge clk);
        chk("req5_addr", mem_addr, 8'h05);
        redirect_addr = 8'h80;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain_req", mem_req, 1);
            chk("drain_addr", mem_addr, 8'h05);
            chk("drain_valid", instr_valid, 0);
            @(negedge clk);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("drain_discard", instr_valid, 0);
        chk("drain_next_addr", mem_addr, 8'h80);
        chk("drain_kept_instr", instr_out, 16'hB040);
        serve(1, 8'h80, 16'hB080);

        // Redirect coinciding with ack in REQ
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready    = 1'b0;
        chk("req81_addr", mem_addr, 8'h81);
        mem_ack        = 1'b1;
        mem_rdata      = 16'hBEEF;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h90;
        @(negedge clk);
        mem_ack        = 1'b0;
        redirect_valid = 1'b0;
        chk("ackredir_valid", instr_valid, 0);
        chk("ackredir_req", mem_req, 1);
        chk("ackredir_addr", mem_addr, 8'h90);
        serve(1, 8'h90, 16'hB090);

        // Reset in the middle of a request, ack during reset
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("pre_rst_req", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_valid", instr_valid, 0);
        chk("async_rst_pc", pc_out, 8'h00);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst_ack_req", mem_req, 0);
        chk("rst_ack_instr", instr_out, 16'h0);
        reset = 1'b0;
        serve(2, 8'h00, 16'hC000);

        // RESET_PC=FE instance wraps FE, FF, 00
        begin
            logic [7:0] exp_addr;
            exp_addr = 8'hFE;
            for (int k = 0; k < 3; k++) begin
                chk("wrap_req", mem_req2, 1);
                chk("wrap_addr", mem_addr2, exp_addr);
                mem_ack2   = 1'b1;
                mem_rdata2 = 16'hE000 + 16'(k);
                @(negedge clk);
                mem_ack2 = 1'b0;
                chk("wrap_valid", instr_valid2, 1);
                chk("wrap_ipc", instr_pc2, exp_addr);
                chk("wrap_instr", instr_out2, 16'hE000 + 16'(k));
                @(negedge clk);
                exp_addr = exp_addr + 8'h01;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
